// File: rtl/cpu_pkg.sv
// Shared encodings for the PC update stage: FSM states, branch types,
// exception causes and the default vector byte addresses.
package cpu_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] EXC_REQ  = 2'd1;
  localparam logic [1:0] EXC_WAIT = 2'd2;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LE = 2'b10,
    BR_GT = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_OPCODE = 2'd1,
    CAUSE_OVF    = 2'd2,
    CAUSE_DIV    = 2'd3
  } cause_e;

  localparam logic [31:0] DEF_VEC_OPCODE = 32'd253;
  localparam logic [31:0] DEF_VEC_OVF    = 32'd254;
  localparam logic [31:0] DEF_VEC_DIV    = 32'd255;

  function automatic logic [31:0] vec_for_cause(
    input logic [1:0]  cause,
    input logic [31:0] vec_opcode,
    input logic [31:0] vec_ovf,
    input logic [31:0] vec_div
  );
    logic [31:0] addr;
    addr = 32'd0;
    case (cause)
      CAUSE_OPCODE: addr = vec_opcode;
      CAUSE_OVF:    addr = vec_ovf;
      CAUSE_DIV:    addr = vec_div;
      default:      addr = 32'd0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluation from the ALU flags.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [1:0] i_branch_type,
  input  logic       i_alu_zero,
  input  logic       i_alu_gt,
  output logic       o_cond
);

  always_comb begin
    o_cond = 1'b0;
    case (i_branch_type)
      BR_EQ:   o_cond = i_alu_zero;
      BR_NE:   o_cond = ~i_alu_zero;
      BR_LE:   o_cond = ~i_alu_gt;
      BR_GT:   o_cond = i_alu_gt;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_update_unit.sv
// PC register stage with EPC capture and the exception-vector fetch sequence.
// Optional build macro PC_ALIGN_CHECK_EN: misaligned taken pc_next raises cause 3.
module pc_update_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          MEM_LAT    = 1,
  parameter logic [31:0] VEC_OPCODE = DEF_VEC_OPCODE,
  parameter logic [31:0] VEC_OVF    = DEF_VEC_OVF,
  parameter logic [31:0] VEC_DIV    = DEF_VEC_DIV,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_type,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div,
  input  logic [7:0]  vec_data,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        vec_rd,
  output logic [31:0] vec_addr,
  output logic        exc_busy,
  output logic [1:0]  exc_cause
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  logic [1:0]  r_state;
  logic [2:0]  r_wait;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic [1:0]  r_cause;

  logic        w_cond;
  logic        w_take;
  logic [1:0]  w_new_cause;
  logic        w_exc_req;

  branch_cond u_branch_cond (
    .i_branch_type (branch_type),
    .i_alu_zero    (alu_zero),
    .i_alu_gt      (alu_gt),
    .o_cond        (w_cond)
  );

  assign w_take = pc_write | (pc_write_cond & w_cond);

  always_comb begin
    w_new_cause = CAUSE_NONE;
    if (exc_opcode)
      w_new_cause = CAUSE_OPCODE;
    else if (exc_ovf)
      w_new_cause = CAUSE_OVF;
    else if (exc_div)
      w_new_cause = CAUSE_DIV;
`ifdef PC_ALIGN_CHECK_EN
    else if (w_take && (pc_next[1:0] != 2'b00))
      w_new_cause = CAUSE_DIV;
`endif
  end

  assign w_exc_req = (w_new_cause != CAUSE_NONE);

  // Requests and writes are only honoured in IDLE; the busy states ignore them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wait  <= 3'd0;
      r_pc    <= RESET_PC;
      r_epc   <= 32'd0;
      r_cause <= CAUSE_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_exc_req) begin
            r_epc   <= r_pc - EPC_OFFSET;
            r_cause <= w_new_cause;
            r_state <= EXC_REQ;
          end else if (w_take) begin
            r_pc <= pc_next;
          end
        end
        EXC_REQ: begin
          r_wait  <= LAT;
          r_state <= EXC_WAIT;
        end
        EXC_WAIT: begin
          if (r_wait == 3'd1) begin
            r_pc    <= {24'b0, vec_data};
            r_wait  <= 3'd0;
            r_state <= IDLE;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pc        = r_pc;
  assign epc       = r_epc;
  assign exc_cause = r_cause;
  assign exc_busy  = (r_state != IDLE);
  assign vec_rd    = (r_state == EXC_REQ);
  assign vec_addr  = vec_rd ? vec_for_cause(r_cause, VEC_OPCODE, VEC_OVF, VEC_DIV) : 32'd0;

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: vector table for PC writes and
// branches, hand sequences for exceptions, MEM_LAT=3 and async reset abort.
module tb_pc_update_unit;

  logic        clk;
  logic        reset;
  logic        reset3;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_type;
  logic        alu_zero;
  logic        alu_gt;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div;
  logic [7:0]  vec_data;

  logic [31:0] pc, epc, vec_addr;
  logic        vec_rd, exc_busy;
  logic [1:0]  exc_cause;

  logic [31:0] pc3, epc3, vec_addr3;
  logic        vec_rd3, exc_busy3;
  logic [1:0]  exc_cause3;

  int n_checks = 0;
  int n_fail   = 0;

  pc_update_unit #(.MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_type(branch_type),
    .alu_zero(alu_zero), .alu_gt(alu_gt), .exc_opcode(exc_opcode),
    .exc_ovf(exc_ovf), .exc_div(exc_div), .vec_data(vec_data),
    .pc(pc), .epc(epc), .vec_rd(vec_rd), .vec_addr(vec_addr),
    .exc_busy(exc_busy), .exc_cause(exc_cause)
  );

  pc_update_unit #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset3), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_type(branch_type),
    .alu_zero(alu_zero), .alu_gt(alu_gt), .exc_opcode(exc_opcode),
    .exc_ovf(exc_ovf), .exc_div(exc_div), .vec_data(vec_data),
    .pc(pc3), .epc(epc3), .vec_rd(vec_rd3), .vec_addr(vec_addr3),
    .exc_busy(exc_busy3), .exc_cause(exc_cause3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pw;
    logic        pwc;
    logic [1:0]  bt;
    logic        z;
    logic        gt;
    logic [31:0] nxt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_next       = 32'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_type   = 2'b00;
    alu_zero      = 1'b0;
    alu_gt        = 1'b0;
    exc_opcode    = 1'b0;
    exc_ovf       = 1'b0;
    exc_div       = 1'b0;
  endtask

  initial begin
    tbl[0] = '{"pw_load",  1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h04, 32'h04};
    tbl[1] = '{"pw_hold",  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h08, 32'h04};
    tbl[2] = '{"beq_nt",   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h40, 32'h04};
    tbl[3] = '{"beq_t",    1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h40, 32'h40};
    tbl[4] = '{"bgt_t",    1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 32'h80, 32'h80};
    tbl[5] = '{"ble_nt",   1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h90, 32'h80};
    tbl[6] = '{"ble_t",    1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 32'h84, 32'h84};
    tbl[7] = '{"bne_t",    1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h20, 32'h20};

    idle_inputs();
    vec_data = 8'h00;
    reset    = 1'b0;
    reset3   = 1'b0;
    tick();
    tick();
    check("rst_pc", pc, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_vec_rd", {31'd0, vec_rd}, 32'd0);
    check("rst_vec_addr", vec_addr, 32'd0);
    check("rst_busy", {31'd0, exc_busy}, 32'd0);
    check("rst_cause", {30'd0, exc_cause}, 32'd0);
    reset = 1'b1;

    // PC write / branch vectors through the scoreboard queue
    for (int i = 0; i < 8; i++) begin
      pc_write      = tbl[i].pw;
      pc_write_cond = tbl[i].pwc;
      branch_type   = tbl[i].bt;
      alu_zero      = tbl[i].z;
      alu_gt        = tbl[i].gt;
      pc_next       = tbl[i].nxt;
      exp_q.push_back(tbl[i].exp_pc);
      tick();
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: scoreboard empty", tbl[i].name);
      end else begin
        check(tbl[i].name, pc, exp_q.pop_front());
      end
      $display("vec %0d %s: pc=%h", i, tbl[i].name, pc);
    end
    idle_inputs();

    // Overflow exception racing a pc_write, pc=0x20
    exc_ovf  = 1'b1;
    pc_write = 1'b1;
    pc_next  = 32'h100;
    tick();
    idle_inputs();
    check("ovf_epc", epc, 32'h1C);
    check("ovf_cause", {30'd0, exc_cause}, 32'd2);
    check("ovf_pc_held", pc, 32'h20);
    check("ovf_vec_rd", {31'd0, vec_rd}, 32'd1);
    check("ovf_vec_addr", vec_addr, 32'd254);
    check("ovf_busy", {31'd0, exc_busy}, 32'd1);
    vec_data = 8'h7A;
    tick();
    check("ovf_vec_rd_low", {31'd0, vec_rd}, 32'd0);
    check("ovf_pc_wait", pc, 32'h20);
    tick();
    check("ovf_pc_load", pc, 32'h7A);
    check("ovf_busy_done", {31'd0, exc_busy}, 32'd0);
    check("ovf_cause_hold", {30'd0, exc_cause}, 32'd2);
    $display("seq ovf: pc=%h epc=%h", pc, epc);

    // Opcode beats div; a div pulse while busy is ignored
    exc_opcode = 1'b1;
    exc_div    = 1'b1;
    tick();
    exc_opcode = 1'b0;
    check("prio_cause", {30'd0, exc_cause}, 32'd1);
    check("prio_vec_addr", vec_addr, 32'd253);
    check("prio_epc", epc, 32'h76);
    vec_data = 8'h33;
    tick();
    check("busy_no_vec_rd", {31'd0, vec_rd}, 32'd0);
    check("busy_epc_kept", epc, 32'h76);
    tick();
    exc_div = 1'b0;
    check("prio_pc_load", pc, 32'h33);
    tick();
    check("busy_no_requeue", {31'd0, vec_rd}, 32'd0);
    check("busy_no_requeue_busy", {31'd0, exc_busy}, 32'd0);
    $display("seq prio: pc=%h epc=%h cause=%0d", pc, epc, exc_cause);

    // Misaligned pc_next
    pc_write = 1'b1;
    pc_next  = 32'h10;
    tick();
    check("align_setup_pc", pc, 32'h10);
    pc_next = 32'h41;
    tick();
    idle_inputs();
`ifdef PC_ALIGN_CHECK_EN
    check("align_pc_held", pc, 32'h10);
    check("align_epc", epc, 32'h0C);
    check("align_cause", {30'd0, exc_cause}, 32'd3);
    check("align_vec_addr", vec_addr, 32'd255);
    vec_data = 8'h10;
    tick();
    tick();
    check("align_pc_load", pc, 32'h10);
`else
    check("noalign_pc", pc, 32'h41);
    check("noalign_busy", {31'd0, exc_busy}, 32'd0);
`endif
    $display("seq align: pc=%h epc=%h", pc, epc);

    // MEM_LAT=3 instance: full sequence from pc=0, then reset abort
    reset3 = 1'b1;
    tick();
    exc_ovf = 1'b1;
    tick();
    exc_ovf = 1'b0;
    check("lat3_epc_wrap", epc3, 32'hFFFF_FFFC);
    check("lat3_vec_rd", {31'd0, vec_rd3}, 32'd1);
    vec_data = 8'h60;
    tick();
    tick();
    tick();
    check("lat3_pc_not_yet", pc3, 32'h0);
    check("lat3_busy_wait", {31'd0, exc_busy3}, 32'd1);
    tick();
    check("lat3_pc_load", pc3, 32'h60);
    check("lat3_busy_done", {31'd0, exc_busy3}, 32'd0);
    $display("seq lat3: pc=%h epc=%h", pc3, epc3);

    exc_div = 1'b1;
    tick();
    exc_div = 1'b0;
    check("abort_epc", epc3, 32'h5C);
    check("abort_cause", {30'd0, exc_cause3}, 32'd3);
    vec_data = 8'h99;
    tick();
    tick();
    #2;
    reset3 = 1'b0;
    #1;
    check("abort_pc", pc3, 32'h0);
    check("abort_busy", {31'd0, exc_busy3}, 32'd0);
    check("abort_vec_rd", {31'd0, vec_rd3}, 32'd0);
    check("abort_cause_clr", {30'd0, exc_cause3}, 32'd0);
    tick();
    reset3 = 1'b1;
    tick();
    tick();
    tick();
    check("abort_no_load", pc3, 32'h0);
    check("abort_idle", {31'd0, exc_busy3}, 32'd0);
    $display("seq abort: pc=%h busy=%0d", pc3, exc_busy3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Program-counter register stage directly downstream of the PC-source mux.
- Each cycle it decides whether the mux output is written into PC: unconditional PCWrite, or PCWriteCond qualified by ALU flags.
- Owns EPC and the exception-vector sequence: on an exception it captures EPC, reads the handler byte from memory at a fixed vector address, and loads PC with it.
- Its pc output feeds the memory address path; its epc output feeds the mux's EPC input.

Parameters:
- RESET_PC, 32'd0, PC value after reset.
- MEM_LAT, 1, cycles from a vec_rd cycle to valid vec_data; legal range 1..4.
- VEC_OPCODE, 32'd253, vector byte address for an invalid-opcode exception.
- VEC_OVF, 32'd254, vector byte address for an overflow exception.
- VEC_DIV, 32'd255, vector byte address for a divide-by-zero exception.
- EPC_OFFSET, 32'd4, value subtracted from PC when EPC is captured.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_next  in  32  candidate PC from the PC-source mux.
- pc_write  in  1  unconditional PC write.
- pc_write_cond  in  1  conditional PC write, qualified by branch_type.
- branch_type  in  2  00 BEQ, 01 BNE, 10 BLE, 11 BGT.
- alu_zero  in  1  ALU zero flag.
- alu_gt  in  1  ALU greater-than flag.
- exc_opcode  in  1  invalid-opcode exception request.
- exc_ovf  in  1  overflow exception request.
- exc_div  in  1  divide-by-zero exception request.
- vec_data  in  8  memory read byte.
- pc  out  32  current program counter.
- epc  out  32  exception program counter.
- vec_rd  out  1  one-cycle memory read strobe.
- vec_addr  out  32  vector address; valid while vec_rd is high.
- exc_busy  out  1  exception sequence in progress.
- exc_cause  out  2  0 none, 1 opcode, 2 overflow, 3 divide-by-zero.

Behaviour:
- Reset (async, reset=0): pc=RESET_PC, epc=0, state=IDLE, wait counter=0, vec_rd=0, vec_addr=0, exc_busy=0, exc_cause=0.
- Reset asserted mid-sequence aborts the sequence immediately; no partial PC load.
- Branch condition:
  - BEQ: alu_zero.
  - BNE: !alu_zero.
  - BLE: !alu_gt.
  - BGT: alu_gt.
- take = pc_write | (pc_write_cond & cond).
- IDLE, no exception request, take=1: pc <= pc_next at the clock edge (1-cycle latency). take=0: pc holds.
- IDLE, any exc_* high:
  - epc <= pc - EPC_OFFSET (mod 2^32; pc=0 gives 32'hFFFFFFFC).
  - Cause latched with priority opcode > ovf > div.
  - Next state EXC_REQ.
  - Exception wins over a simultaneous take; pc is unchanged that edge.
- EXC_REQ (1 cycle): vec_rd=1, vec_addr=vector for the latched cause, exc_busy=1. Next state EXC_WAIT, counter=MEM_LAT.
- EXC_WAIT: exc_busy=1, vec_rd=0. Counter decrements each cycle. In the cycle the counter equals 1: pc <= {24'b0, vec_data} at that edge; next state IDLE.
- Timing with MEM_LAT=1: exception sampled at edge E0; vec_rd high during cycle E0..E1; pc holds the new value after E2.
- While exc_busy=1:
  - pc_write, pc_write_cond and all exc_* inputs are ignored; nothing is queued.
  - epc is not overwritten.
- exc_cause holds the last cause until the next exception or reset.
- An exception request arriving on the first IDLE cycle after a sequence is accepted normally; back-to-back exceptions are allowed.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a take with pc_next[1:0]!=0 is treated as an exception of cause 3 (divide-by-zero vector reused).
  - epc captures pc - EPC_OFFSET; the misaligned pc_next is discarded.
  - Priority is below the three exc_* inputs.
- Not defined: pc_next is loaded unchecked and bits [1:0] are stored as given.

Decomposition:
- Shared package (cpu_pkg):
  - State encoding IDLE/EXC_REQ/EXC_WAIT.
  - branch_type codes BR_EQ/BR_NE/BR_LE/BR_GT.
  - Cause codes CAUSE_NONE/OPCODE/OVF/DIV.
  - Default vector address constants.
- One natural sub-module: branch_cond, purely combinational, (branch_type, alu_zero, alu_gt) -> cond.
- FSM, PC register and EPC stay in the top module.

Test Plan:
- Reset release, then pc_write=1 with pc_next=32'h0000_0004 -> pc=4 after one edge. pc_write=0 -> pc holds 4.
- pc_write_cond=1, BEQ, alu_zero=0, pc_next=32'h40 -> pc unchanged. Then alu_zero=1 -> pc=32'h40. Repeat BGT with alu_gt=1 -> taken, and BLE with alu_gt=1 -> not taken.
- pc=32'h20, exc_ovf=1 and pc_write=1 in the same cycle:
  - epc=32'h1C, exc_cause=2, pc not written.
  - vec_rd pulses one cycle with vec_addr=254.
  - vec_data=8'h7A -> pc=32'h7A exactly 3 edges after the exception (MEM_LAT=1), exc_busy=0.
- exc_opcode and exc_div both high -> cause 1, vec_addr=253. A pulse of exc_div during exc_busy is ignored: no second vec_rd, epc unchanged.
- MEM_LAT=3: vec_rd to pc load spans 3 EXC_WAIT cycles. reset=0 asserted during the second EXC_WAIT cycle -> pc=RESET_PC, exc_busy=0 and vec_rd=0 asynchronously, and no load after release.
- With PC_ALIGN_CHECK_EN, pc_write with pc_next=32'h41 from pc=32'h10 -> epc=32'h0C, cause 3, vec_addr=255. Without the macro -> pc=32'h41.
